// File: rtl/vscale_dmem_responder.sv
// rtl/vscale_dmem_responder.sv - data-memory responder with word SRAM model and programmable wait states
//
// Purpose: accepts dmem load/store requests in the address phase (DX) and
//          completes them in the data phase (WB). The block stalls the pipeline
//          through dmem_wait and flags illegal accesses on dmem_badmem_e.
//          Loads are returned sign- or zero-extended.
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   dmem_en        request valid (address phase)
//   dmem_wen       1 = store, 0 = load
//   dmem_size      funct3 size code: 0 B, 1 H, 2 W, 4 BU, 5 HU
//   dmem_addr      byte address (address phase)
//   dmem_wdata     right-justified store data, sampled in the completing cycle
//   dmem_rdata     extended load result in the completing cycle, else 0
//   dmem_wait      data phase still pending
//   dmem_badmem_e  access error, asserted in the completing cycle only
`timescale 1ns/1ps
module vscale_dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dmem_en,
   input  logic        dmem_wen,
   input  logic [2:0]  dmem_size,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_wait,
   output logic        dmem_badmem_e
);

   localparam int          AW         = $clog2(DEPTH_WORDS);
   localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
   localparam logic [3:0]  LAT        = 4'(LATENCY);

   if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $error("vscale_dmem_responder: LATENCY must be within 0..15");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DATA
   } state_t;

   state_t         state;
   state_t         state_n;
   logic [3:0]     cnt;
   logic [3:0]     cnt_n;

   // Request fields captured at accept; only the bits needed later are kept.
   logic           r_wen;
   logic [2:0]     r_size;
   logic [1:0]     r_lane;
   logic [AW-1:0]  r_widx;
   logic           r_err;

   logic [31:0]    mem [DEPTH_WORDS];

   logic           accept;
   logic           req_legal;
   logic           completing;
   logic           mem_we;
   logic [3:0]     be;
   logic [31:0]    wd_rep;
   logic [31:0]    rd_word;
   logic [7:0]     rd_byte;
   logic [15:0]    rd_half;
   logic [31:0]    rd_ext;

   assign dmem_wait  = (state == S_WAIT);
   assign accept     = dmem_en && !dmem_wait;
   assign completing = (state == S_DATA);

   // Legality is judged on the live request so an illegal access can skip
   // the wait states and report its error in the very next cycle.
   always_comb begin
      req_legal = 1'b1;
      case (dmem_size)
         3'd0, 3'd4: req_legal = 1'b1;
         3'd1, 3'd5: if (dmem_addr[0]) req_legal = 1'b0;
         3'd2:       if (dmem_addr[1:0] != 2'b00) req_legal = 1'b0;
         default:    req_legal = 1'b0;
      endcase
      if (dmem_wen && dmem_size[2]) req_legal = 1'b0;
      if ({1'b0, dmem_addr} >= ADDR_LIMIT) req_legal = 1'b0;
   end

   // Next-state logic. The wait counter starts at 1 in the first wait cycle so
   // that exactly LATENCY wait cycles elapse before DATA.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         S_WAIT: begin
            if (cnt == LAT) state_n = S_DATA;
            else            cnt_n   = cnt + 4'd1;
         end
         default: begin
            if (accept) begin
               if (req_legal && (LAT != 4'd0)) begin
                  state_n = S_WAIT;
                  cnt_n   = 4'd1;
               end else begin
                  state_n = S_DATA;
               end
            end else begin
               state_n = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
         r_wen <= 1'b0;
         r_err <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept) begin
            r_wen  <= dmem_wen;
            r_size <= dmem_size;
            r_lane <= dmem_addr[1:0];
            r_widx <= dmem_addr[AW+1:2];
            r_err  <= !req_legal;
         end
      end
   end

   // Store path: narrow data is replicated across lanes and the byte enables
   // pick the lanes actually written.
   always_comb begin
      be     = 4'b0000;
      wd_rep = dmem_wdata;
      case (r_size)
         3'd0: begin
            be     = 4'b0001 << r_lane;
            wd_rep = {4{dmem_wdata[7:0]}};
         end
         3'd1: begin
            be     = r_lane[1] ? 4'b1100 : 4'b0011;
            wd_rep = {2{dmem_wdata[15:0]}};
         end
         3'd2: be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   // Reset in the completing cycle also suppresses the write.
   assign mem_we = !reset && completing && r_wen && !r_err;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[r_widx][8*b +: 8] <= wd_rep[8*b +: 8];
         end
      end
   end

   // Load path: asynchronous read in the completing cycle, so a store that
   // wrote on the previous edge is already visible.
   assign rd_word = mem[r_widx];
   assign rd_byte = rd_word[8*r_lane +: 8];
   assign rd_half = r_lane[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      case (r_size)
         3'd0:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
         3'd1:    rd_ext = {{16{rd_half[15]}}, rd_half};
         3'd2:    rd_ext = rd_word;
         3'd4:    rd_ext = {24'd0, rd_byte};
         3'd5:    rd_ext = {16'd0, rd_half};
         default: rd_ext = 32'd0;
      endcase
   end

   assign dmem_rdata    = (completing && !r_wen && !r_err) ? rd_ext : 32'd0;
   assign dmem_badmem_e = completing && r_err;

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// tb/tb_vscale_dmem_responder.sv - scoreboard bench for vscale_dmem_responder (LATENCY 0 and 3)
`timescale 1ns/1ps
module tb_vscale_dmem_responder;

   typedef struct {
      int          acc;
      int          due;
      logic [31:0] rd;
      logic [31:0] wd;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst    [2];
   logic        en     [2];
   logic        wen    [2];
   logic [2:0]  size   [2];
   logic [31:0] addr   [2];
   logic [31:0] wdata  [2];
   logic [31:0] rdata  [2];
   logic        waitw  [2];
   logic        bad    [2];
   logic        mon_on [2];

   exp_t sbq [2][$];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vscale_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut0 (
      .clk(clk), .reset(rst[0]), .dmem_en(en[0]), .dmem_wen(wen[0]),
      .dmem_size(size[0]), .dmem_addr(addr[0]), .dmem_wdata(wdata[0]),
      .dmem_rdata(rdata[0]), .dmem_wait(waitw[0]), .dmem_badmem_e(bad[0])
   );

   vscale_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut1 (
      .clk(clk), .reset(rst[1]), .dmem_en(en[1]), .dmem_wen(wen[1]),
      .dmem_size(size[1]), .dmem_addr(addr[1]), .dmem_wdata(wdata[1]),
      .dmem_rdata(rdata[1]), .dmem_wait(waitw[1]), .dmem_badmem_e(bad[1])
   );

   function automatic int lat(input int i);
      return (i == 0) ? 0 : 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Drive one request in the current cycle and record its expected completion.
   task automatic issue(input int i, input logic w, input logic [2:0] s,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic e);
      exp_t x;
      en[i]   = 1'b1;
      wen[i]  = w;
      size[i] = s;
      addr[i] = a;
      x.acc   = cyc;
      x.due   = cyc + 1 + (e ? 0 : lat(i));
      x.rd    = rd;
      x.wd    = w ? wd : $urandom();
      x.err   = e;
      sbq[i].push_back(x);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int i, input int n);
      en[i] = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard monitor: supplies store data in the completing cycle and checks
   // every cycle's outputs against the oldest outstanding expectation.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mon_on[i]) begin
            if (sbq[i].size() > 0) wdata[i] = sbq[i][0].wd;
            if (sbq[i].size() > 0 && sbq[i][0].due == cyc) begin
               chk($sformatf("i%0d_c%0d_done_wait", i, cyc), waitw[i], 0);
               chk($sformatf("i%0d_c%0d_done_err", i, cyc), bad[i], sbq[i][0].err);
               chk($sformatf("i%0d_c%0d_done_rdata", i, cyc), rdata[i], sbq[i][0].rd);
               void'(sbq[i].pop_front());
            end else begin
               chk($sformatf("i%0d_c%0d_wait", i, cyc), waitw[i],
                   (sbq[i].size() > 0 && sbq[i][0].acc < cyc && sbq[i][0].due > cyc));
               chk($sformatf("i%0d_c%0d_err_idle", i, cyc), bad[i], 0);
               chk($sformatf("i%0d_c%0d_rdata_idle", i, cyc), rdata[i], 0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; en[i] = 1'b0; wen[i] = 1'b0; size[i] = 3'd0;
         addr[i] = 32'd0; wdata[i] = 32'd0; mon_on[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("reset_wait_%0d", i), waitw[i], 0);
         chk($sformatf("reset_err_%0d", i), bad[i], 0);
         chk($sformatf("reset_rdata_%0d", i), rdata[i], 0);
         rst[i] = 1'b0;
         mon_on[i] = 1'b1;
      end
      @(negedge clk);

      // LATENCY 0, back-to-back traffic
      issue(0, 1, 3'd2, 32'h10,   32'h11223344, 32'h0,        0);
      issue(0, 0, 3'd2, 32'h10,   32'h0,        32'h11223344, 0);
      issue(0, 0, 3'd0, 32'h13,   32'h0,        32'h00000011, 0);
      issue(0, 1, 3'd0, 32'h11,   32'hABCDEF80, 32'h0,        0);
      issue(0, 0, 3'd0, 32'h11,   32'h0,        32'hFFFFFF80, 0);
      issue(0, 0, 3'd4, 32'h11,   32'h0,        32'h00000080, 0);
      issue(0, 0, 3'd1, 32'h10,   32'h0,        32'hFFFF8044, 0);
      issue(0, 0, 3'd5, 32'h12,   32'h0,        32'h00001122, 0);
      issue(0, 1, 3'd2, 32'h20,   32'h11223344, 32'h0,        0);
      issue(0, 1, 3'd1, 32'h22,   32'h1234BEEF, 32'h0,        0);
      issue(0, 0, 3'd2, 32'h20,   32'h0,        32'hBEEF3344, 0);
      issue(0, 0, 3'd1, 32'h21,   32'h0,        32'h0,        1);
      issue(0, 1, 3'd1, 32'h21,   32'h0000AAAA, 32'h0,        1);
      issue(0, 0, 3'd2, 32'h20,   32'h0,        32'hBEEF3344, 0);
      issue(0, 1, 3'd2, 32'h0,    32'h600D600D, 32'h0,        0);
      issue(0, 1, 3'd2, 32'h1000, 32'hFFFFFFFF, 32'h0,        1);
      issue(0, 0, 3'd2, 32'h0,    32'h0,        32'h600D600D, 0);
      issue(0, 0, 3'd2, 32'h1000, 32'h0,        32'h0,        1);
      issue(0, 1, 3'd2, 32'hFFC,  32'h89ABCDEF, 32'h0,        0);
      issue(0, 0, 3'd1, 32'hFFE,  32'h0,        32'hFFFF89AB, 0);
      issue(0, 0, 3'd4, 32'hFFF,  32'h0,        32'h00000089, 0);
      issue(0, 0, 3'd3, 32'h10,   32'h0,        32'h0,        1);
      issue(0, 1, 3'd4, 32'h10,   32'h000000EE, 32'h0,        1);
      issue(0, 0, 3'd2, 32'h22,   32'h0,        32'h0,        1);
      issue(0, 1, 3'd0, 32'h23,   32'h0000005A, 32'h0,        0);
      issue(0, 0, 3'd2, 32'h20,   32'h0,        32'h5AEF3344, 0);
      issue(0, 0, 3'd0, 32'h10,   32'h0,        32'h00000044, 0);
      idle(0, 2);

      // LATENCY 3: wait states, back-to-back in the completing cycle
      issue(1, 1, 3'd2, 32'h80,   32'hCAFEF00D, 32'h0,        0);
      idle(1, 3);
      issue(1, 0, 3'd2, 32'h80,   32'h0,        32'hCAFEF00D, 0);
      // requests during wait must be ignored (an accepted one would flag an error)
      en[1] = 1'b1; wen[1] = 1'b0; size[1] = 3'd1; addr[1] = 32'h21;
      repeat (3) @(negedge clk);
      issue(1, 0, 3'd1, 32'h21,   32'h0,        32'h0,        1);
      issue(1, 0, 3'd2, 32'h1000, 32'h0,        32'h0,        1);
      issue(1, 0, 3'd2, 32'h80,   32'h0,        32'hCAFEF00D, 0);
      idle(1, 4);

      // LATENCY 3: reset in the middle of a store aborts it
      issue(1, 1, 3'd2, 32'h40,   32'h12345678, 32'h0,        0);
      idle(1, 5);
      mon_on[1] = 1'b0;
      en[1] = 1'b1; wen[1] = 1'b1; size[1] = 3'd2; addr[1] = 32'h40; wdata[1] = 32'hDEADBEEF;
      @(negedge clk);
      en[1] = 1'b0;
      chk("rst_pending_wait", waitw[1], 1);
      @(negedge clk);
      rst[1] = 1'b1;
      @(negedge clk);
      chk("rst_abort_wait", waitw[1], 0);
      chk("rst_abort_err", bad[1], 0);
      chk("rst_abort_rdata", rdata[1], 0);
      rst[1] = 1'b0;
      repeat (4) @(negedge clk);
      mon_on[1] = 1'b1;
      issue(1, 0, 3'd2, 32'h40,   32'h0,        32'h12345678, 0);
      idle(1, 1);

      for (int k = 0; k < 20 && (sbq[0].size() != 0 || sbq[1].size() != 0); k++)
         @(negedge clk);
      chk("drain_q0", sbq[0].size(), 0);
      chk("drain_q1", sbq[1].size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
